// File: rtl/synth_bus_master.sv
// Single-request initiator for the synth register bus: each accepted request becomes
// one SETUP / HIGH / HOLD strobe sequence on BusClock, ending with a one-cycle done pulse.
module synth_bus_master #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [15:0] req_addr_i,
    input  logic [7:0]  req_data_i,
    output logic        done_o,
    output logic [7:0]  rd_data_o,
    output logic [15:0] bus_address_o,
    inout  wire  [7:0]  bus_data_io,
    output logic        bus_read_write_o,
    output logic        bus_clock_o,
    output logic [1:0]  state_o
);

    // Handshake: a request transfers on a clk_i rising edge where req_valid_i and
    // req_ready_o are both 1; the requester holds its request stable until then.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_HIGH  = 2'd2,
        S_HOLD  = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;
    logic [7:0]         rd_q, rd_d;
    logic [15:0]        addr_q, addr_d;
    logic [7:0]         wdata_q, wdata_d;
    logic               rw_q, rw_d;
    logic               bclk_q, bclk_d;
    logic               phase_end;

    assign phase_end = (cnt_q == CNT_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            rd_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rw_q    <= 1'b1;
            bclk_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rw_q    <= rw_d;
            bclk_q  <= bclk_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        done_d  = 1'b0;
        rd_d    = rd_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rw_d    = rw_q;
        bclk_d  = bclk_q;
        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                bclk_d  = 1'b0;
                rw_d    = 1'b1;
                if (req_valid_i && ready_q) begin
                    addr_d  = req_addr_i;
                    rw_d    = req_write_i;
                    if (req_write_i) begin
                        wdata_d = req_data_i;
                    end
                    cnt_d   = '0;
                    ready_d = 1'b0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (phase_end) begin
                    cnt_d   = '0;
                    bclk_d  = 1'b1;
                    state_d = S_HIGH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HIGH: begin
                if (phase_end) begin
                    cnt_d   = '0;
                    bclk_d  = 1'b0;
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (phase_end) begin
                    // Slave is still driving here because rw_q only returns to 1 at this edge.
                    if (!rw_q) begin
                        rd_d = bus_data_io;
                    end
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    rw_d    = 1'b1;
                    ready_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus_data_io      = rw_q ? wdata_q : 8'hzz;
    assign req_ready_o      = ready_q;
    assign done_o           = done_q;
    assign rd_data_o        = rd_q;
    assign bus_address_o    = addr_q;
    assign bus_read_write_o = rw_q;
    assign bus_clock_o      = bclk_q;
    assign state_o          = state_q;

endmodule
